dm_sba_engine: RTL and testbench
================================

DM_SBA_ENGINE -- requirements
Module: dm_sba_engine

Interface
REQ-001 Parameter BusWidth, default 32, width of system-bus address and data in bits; legal values 32 and 64.
REQ-002 Port clk_i  input  1  rising-edge clock, sole clock domain.
REQ-003 Port rst_i  input  1  reset, synchronous and active-high.
REQ-004 Port dmactive_i  input  1  debug-module active; low acts as synchronous clear.
REQ-005 Port sbaddress_i / sbaddress_we_i  input  BusWidth / 1  debugger write of sbaddress0(-1).
REQ-006 Port sbdata_i / sbdata_we_i  input  BusWidth / 1  debugger write of sbdata0(-1).
REQ-007 Port sbdata_re_i  input  1  debugger read of sbdata0.
REQ-008 Port sbaccess_i  input  3  access size, log2 bytes.
REQ-009 Port sbreadonaddr_i / sbreadondata_i / sbautoincrement_i  input  1 each  sbcs mode bits.
REQ-010 Port sberror_clr_i / sbbusyerror_clr_i  input  1 each  write-1-to-clear strobes.
REQ-011 Port sbaddress_o / sbdata_o  output  BusWidth  current address and data registers.
REQ-012 Port sbbusy_o / sbbusyerror_o  output  1 each; sberror_o  output  3.
REQ-013 Port req_o, we_o  output  1; addr_o, wdata_o  output  BusWidth; be_o  output  BusWidth/8.
REQ-014 Port gnt_i, rvalid_i, err_i  input  1; rdata_i  input  BusWidth.

Function
REQ-015 FSM states IDLE, REQ, WAIT; sbbusy_o = (state != IDLE).
REQ-016 Trigger: sbaddress_we_i updates sbaddress; starts a read if sbreadonaddr_i.
REQ-017 Trigger: sbdata_we_i updates sbdata; starts a write.
REQ-018 Trigger: sbdata_re_i with sbreadondata_i starts a read after sbdata_o is returned.
REQ-019 No trigger starts an access while sberror_o != 0 or sbbusyerror_o = 1; register updates still occur when IDLE.
REQ-020 Any trigger while sbbusy_o = 1 sets sbbusyerror_o, leaves registers unchanged, and the in-flight access continues.
REQ-021 Simultaneous sbaddress_we_i and sbdata_we_i: address written, read-on-address suppressed, write launched with the new address.
REQ-022 Size check at trigger: 2**sbaccess_i > BusWidth/8 -> sberror_o = 4, state stays IDLE, no bus request.
REQ-023 Alignment check at trigger: sbaddress not aligned to 2**sbaccess_i -> sberror_o = 3, no bus request; size check wins if both fail.
REQ-024 Legal trigger in cycle N -> state REQ, req_o = 1 in N+1; req_o, we_o, addr_o, wdata_o, be_o held stable until gnt_i.
REQ-025 addr_o = sbaddress with the low log2(BusWidth/8) bits zeroed.
REQ-026 be_o = ((1 << 2**sbaccess) - 1) << offset, where offset = sbaddress byte offset within the bus word.
REQ-027 wdata_o = sbdata shifted left by 8*offset.
REQ-028 gnt_i high in REQ -> WAIT next cycle, req_o low; the response arrives as a one-cycle rvalid_i pulse, earliest the cycle after the grant.
REQ-029 rvalid_i in WAIT (cycle K): at K+1 state = IDLE, sbbusy_o = 0.
REQ-030 On a successful read, sbdata_o = (rdata_i >> 8*offset) masked to 2**sbaccess bytes, zero-extended.
REQ-031 rvalid_i with err_i -> sberror_o = 2, sbdata and sbaddress unchanged.
REQ-032 Success with sbautoincrement_i -> sbaddress += 2**sbaccess, modulo 2**BusWidth (wraps to 0).
REQ-033 sberror_clr_i zeroes sberror_o and sbbusyerror_clr_i clears sbbusyerror_o, in any state; a clear and a set in the same cycle: the set wins.
REQ-034 rvalid_i outside WAIT is ignored.

Reset
REQ-035 rst_i = 1 or dmactive_i = 0 at a clock edge -> next cycle: state IDLE; sbaddress_o, sbdata_o, sberror_o = 0; sbbusy_o, sbbusyerror_o, req_o, we_o = 0; addr_o, wdata_o, be_o = 0.
REQ-036 Clear mid-access aborts: req_o drops next cycle and any later rvalid_i of the aborted access is ignored.

Verification
REQ-037 BusWidth=32, sbaccess=2, readonaddr=1, write sbaddress=0x1000, gnt +2 cycles, rvalid rdata=0xDEADBEEF -> req_o at N+1, sbdata_o=0xDEADBEEF, sbbusy_o low at K+1.
REQ-038 BusWidth=64, sbaccess=1, autoincrement, sbaddress=0x1006, write sbdata=0xA5A5 -> be_o=0xC0, wdata_o[63:48]=0xA5A5, sbaddress_o=0x1008 after rvalid.
REQ-039 sbaccess=3 with BusWidth=32 -> sberror_o=4, no req_o; sbaccess=2 with address 0x1002 -> sberror_o=3; sberror_clr_i -> 0.
REQ-040 sbdata write while busy -> sbbusyerror_o=1, first access completes unchanged, next trigger blocked until sbbusyerror_clr_i.
REQ-041 rvalid with err_i -> sberror_o=2, sbaddress not incremented; autoincrement at 0xFFFFFFFC, size 4 -> sbaddress_o=0x0.
REQ-042 dmactive_i low while in WAIT -> IDLE next cycle, all outputs 0, late rvalid_i ignored.

Source files
------------

// File: rtl/dm_sba_engine.sv
// System-bus access engine for a debug module: turns sbaddress/sbdata
// register traffic into single bus transactions and tracks sbcs error state.
//
// state | meaning
// IDLE  | no access in flight; register writes and triggers accepted
// REQ   | req_o asserted, request fields held until gnt_i
// WAIT  | granted, waiting for the one-cycle rvalid_i response
module dm_sba_engine #(
    parameter int BusWidth = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  dmactive_i,
    input  logic [BusWidth-1:0]   sbaddress_i,
    input  logic                  sbaddress_we_i,
    input  logic [BusWidth-1:0]   sbdata_i,
    input  logic                  sbdata_we_i,
    input  logic                  sbdata_re_i,
    input  logic [2:0]            sbaccess_i,
    input  logic                  sbreadonaddr_i,
    input  logic                  sbreadondata_i,
    input  logic                  sbautoincrement_i,
    input  logic                  sberror_clr_i,
    input  logic                  sbbusyerror_clr_i,
    output logic [BusWidth-1:0]   sbaddress_o,
    output logic [BusWidth-1:0]   sbdata_o,
    output logic                  sbbusy_o,
    output logic                  sbbusyerror_o,
    output logic [2:0]            sberror_o,
    output logic                  req_o,
    output logic                  we_o,
    output logic [BusWidth-1:0]   addr_o,
    output logic [BusWidth-1:0]   wdata_o,
    output logic [BusWidth/8-1:0] be_o,
    input  logic                  gnt_i,
    input  logic                  rvalid_i,
    input  logic                  err_i,
    input  logic [BusWidth-1:0]   rdata_i
);

    localparam int Bytes = BusWidth / 8;
    localparam int OffW  = $clog2(Bytes);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

    state_e              state;
    logic [BusWidth-1:0] sbaddress, sbdata;
    logic [2:0]          sberror;
    logic                sbbusyerror;
    logic [2:0]          acc_size;
    logic [OffW-1:0]     acc_off;

    logic                trig_any, start_wr, start_rd, blocked, size_bad, misalign;
    logic [BusWidth-1:0] eff_addr, eff_data, align_mask, rd_shift, rd_mask, rd_data;
    logic [OffW-1:0]     eff_off;
    logic [7:0]          nbytes, acc_bytes;
    logic [Bytes-1:0]    be_base;

    always_comb begin
        trig_any   = sbaddress_we_i | sbdata_we_i | (sbdata_re_i & sbreadondata_i);
        start_wr   = sbdata_we_i;
        // A simultaneous data write turns the access into a write, so read-on-address is dropped.
        start_rd   = !sbdata_we_i && ((sbaddress_we_i && sbreadonaddr_i) ||
                                      (sbdata_re_i && sbreadondata_i));
        blocked    = (sberror != 3'd0) || sbbusyerror;
        eff_addr   = sbaddress_we_i ? sbaddress_i : sbaddress;
        eff_data   = sbdata_we_i ? sbdata_i : sbdata;
        eff_off    = eff_addr[OffW-1:0];
        nbytes     = 8'd1 << sbaccess_i;
        size_bad   = nbytes > 8'(Bytes);
        align_mask = ~({BusWidth{1'b1}} << sbaccess_i);
        misalign   = (eff_addr & align_mask) != '0;
        be_base    = ~({Bytes{1'b1}} << nbytes);
        acc_bytes  = 8'd1 << acc_size;
        rd_shift   = rdata_i >> {acc_off, 3'b000};
        rd_mask    = ~({BusWidth{1'b1}} << {acc_bytes, 3'b000});
        rd_data    = rd_shift & rd_mask;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || !dmactive_i) begin
            state       <= IDLE;
            sbaddress   <= '0;
            sbdata      <= '0;
            sberror     <= 3'd0;
            sbbusyerror <= 1'b0;
            req_o       <= 1'b0;
            we_o        <= 1'b0;
            addr_o      <= '0;
            wdata_o     <= '0;
            be_o        <= '0;
            acc_size    <= 3'd0;
            acc_off     <= '0;
        end else begin
            // Clears first so that any set later in this block takes priority.
            if (sberror_clr_i)     sberror     <= 3'd0;
            if (sbbusyerror_clr_i) sbbusyerror <= 1'b0;
            case (state)
                IDLE: begin
                    if (sbaddress_we_i) sbaddress <= sbaddress_i;
                    if (sbdata_we_i)    sbdata    <= sbdata_i;
                    if ((start_wr || start_rd) && !blocked) begin
                        if (size_bad) begin
                            sberror <= 3'd4;
                        end else if (misalign) begin
                            sberror <= 3'd3;
                        end else begin
                            state    <= REQ;
                            req_o    <= 1'b1;
                            we_o     <= start_wr;
                            addr_o   <= eff_addr & ~BusWidth'(Bytes - 1);
                            be_o     <= be_base << eff_off;
                            wdata_o  <= eff_data << {eff_off, 3'b000};
                            acc_size <= sbaccess_i;
                            acc_off  <= eff_off;
                        end
                    end
                end
                REQ: begin
                    if (trig_any) sbbusyerror <= 1'b1;
                    if (gnt_i) begin
                        state <= WAIT;
                        req_o <= 1'b0;
                    end
                end
                WAIT: begin
                    if (trig_any) sbbusyerror <= 1'b1;
                    if (rvalid_i) begin
                        state <= IDLE;
                        if (err_i) begin
                            sberror <= 3'd2;
                        end else begin
                            if (!we_o) sbdata <= rd_data;
                            if (sbautoincrement_i)
                                sbaddress <= sbaddress + BusWidth'(acc_bytes);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sbaddress_o   = sbaddress;
    assign sbdata_o      = sbdata;
    assign sberror_o     = sberror;
    assign sbbusyerror_o = sbbusyerror;
    assign sbbusy_o      = (state != IDLE);

endmodule

// File: tb/tb_dm_sba_engine.sv
// Directed bench for dm_sba_engine: a 32-bit and a 64-bit instance share
// stimulus, with per-instance strobes gated by sel64.
module tb_dm_sba_engine;

    logic        clk = 1'b0;
    logic        rst, dmactive, sel64;
    logic [63:0] sbaddress, sbdata, rdata;
    logic        sbaddress_we, sbdata_we, sbdata_re;
    logic [2:0]  sbaccess;
    logic        roa, rod, ainc, err_clr, berr_clr;
    logic        gnt, rvalid, err;

    logic [31:0] a_sbaddress, a_sbdata, a_addr, a_wdata;
    logic        a_busy, a_berr, a_req, a_we;
    logic [2:0]  a_err;
    logic [3:0]  a_be;
    logic [63:0] b_sbaddress, b_sbdata, b_addr, b_wdata;
    logic        b_busy, b_berr, b_req, b_we;
    logic [2:0]  b_err;
    logic [7:0]  b_be;

    logic [63:0] m_sbaddress, m_sbdata, m_addr, m_wdata;
    logic        m_busy, m_berr, m_req, m_we;
    logic [2:0]  m_err;
    logic [7:0]  m_be;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dm_sba_engine #(.BusWidth(32)) u32 (
        .clk_i(clk), .rst_i(rst), .dmactive_i(dmactive),
        .sbaddress_i(sbaddress[31:0]), .sbaddress_we_i(sbaddress_we & ~sel64),
        .sbdata_i(sbdata[31:0]), .sbdata_we_i(sbdata_we & ~sel64),
        .sbdata_re_i(sbdata_re & ~sel64), .sbaccess_i(sbaccess),
        .sbreadonaddr_i(roa), .sbreadondata_i(rod), .sbautoincrement_i(ainc),
        .sberror_clr_i(err_clr), .sbbusyerror_clr_i(berr_clr),
        .sbaddress_o(a_sbaddress), .sbdata_o(a_sbdata), .sbbusy_o(a_busy),
        .sbbusyerror_o(a_berr), .sberror_o(a_err),
        .req_o(a_req), .we_o(a_we), .addr_o(a_addr), .wdata_o(a_wdata), .be_o(a_be),
        .gnt_i(gnt & ~sel64), .rvalid_i(rvalid & ~sel64), .err_i(err), .rdata_i(rdata[31:0])
    );

    dm_sba_engine #(.BusWidth(64)) u64 (
        .clk_i(clk), .rst_i(rst), .dmactive_i(dmactive),
        .sbaddress_i(sbaddress), .sbaddress_we_i(sbaddress_we & sel64),
        .sbdata_i(sbdata), .sbdata_we_i(sbdata_we & sel64),
        .sbdata_re_i(sbdata_re & sel64), .sbaccess_i(sbaccess),
        .sbreadonaddr_i(roa), .sbreadondata_i(rod), .sbautoincrement_i(ainc),
        .sberror_clr_i(err_clr), .sbbusyerror_clr_i(berr_clr),
        .sbaddress_o(b_sbaddress), .sbdata_o(b_sbdata), .sbbusy_o(b_busy),
        .sbbusyerror_o(b_berr), .sberror_o(b_err),
        .req_o(b_req), .we_o(b_we), .addr_o(b_addr), .wdata_o(b_wdata), .be_o(b_be),
        .gnt_i(gnt & sel64), .rvalid_i(rvalid & sel64), .err_i(err), .rdata_i(rdata)
    );

    always_comb begin
        m_sbaddress = sel64 ? b_sbaddress : {32'h0, a_sbaddress};
        m_sbdata    = sel64 ? b_sbdata    : {32'h0, a_sbdata};
        m_addr      = sel64 ? b_addr      : {32'h0, a_addr};
        m_wdata     = sel64 ? b_wdata     : {32'h0, a_wdata};
        m_busy      = sel64 ? b_busy      : a_busy;
        m_berr      = sel64 ? b_berr      : a_berr;
        m_req       = sel64 ? b_req       : a_req;
        m_we        = sel64 ? b_we        : a_we;
        m_err       = sel64 ? b_err       : a_err;
        m_be        = sel64 ? b_be        : {4'h0, a_be};
    end

    typedef struct {
        bit          w64;
        logic [2:0]  acc;
        logic [63:0] addr;
        logic [63:0] data;
        logic [2:0]  exp_err;
        logic [7:0]  exp_be;
        logic [63:0] exp_addr;
        logic [63:0] exp_wdata;
    } vec_t;

    vec_t vecs[11];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wr_addr(input logic [63:0] a);
        sbaddress = a;
        sbaddress_we = 1'b1;
        tick();
        sbaddress_we = 1'b0;
    endtask

    task automatic wr_data(input logic [63:0] d);
        sbdata = d;
        sbdata_we = 1'b1;
        tick();
        sbdata_we = 1'b0;
    endtask

    task automatic finish_access(input logic [63:0] rd);
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        rdata = rd;
        rvalid = 1'b1;
        tick();
        rvalid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; dmactive = 1'b1; sel64 = 1'b0;
        sbaddress = '0; sbdata = '0; rdata = '0;
        sbaddress_we = 1'b0; sbdata_we = 1'b0; sbdata_re = 1'b0; sbaccess = 3'd2;
        roa = 1'b0; rod = 1'b0; ainc = 1'b0; err_clr = 1'b0; berr_clr = 1'b0;
        gnt = 1'b0; rvalid = 1'b0; err = 1'b0;

        //          w64  acc   addr                  data                    err   be     addr_o                wdata
        vecs[0]  = '{1'b0, 3'd2, 64'h1000,             64'h11223344,           3'd0, 8'h0F, 64'h1000,             64'h11223344};
        vecs[1]  = '{1'b0, 3'd0, 64'h1003,             64'hAB,                 3'd0, 8'h08, 64'h1000,             64'hAB000000};
        vecs[2]  = '{1'b0, 3'd1, 64'h1002,             64'hBEEF,               3'd0, 8'h0C, 64'h1000,             64'hBEEF0000};
        vecs[3]  = '{1'b0, 3'd3, 64'h1000,             64'h1,                  3'd4, 8'h00, 64'h0,                64'h0};
        vecs[4]  = '{1'b0, 3'd2, 64'h1002,             64'h1,                  3'd3, 8'h00, 64'h0,                64'h0};
        vecs[5]  = '{1'b0, 3'd3, 64'h1001,             64'h1,                  3'd4, 8'h00, 64'h0,                64'h0};
        vecs[6]  = '{1'b1, 3'd1, 64'h1006,             64'hA5A5,               3'd0, 8'hC0, 64'h1000,             64'hA5A5000000000000};
        vecs[7]  = '{1'b1, 3'd3, 64'h2008,             64'h0123456789ABCDEF,   3'd0, 8'hFF, 64'h2008,             64'h0123456789ABCDEF};
        vecs[8]  = '{1'b1, 3'd2, 64'h2004,             64'hCAFEF00D,           3'd0, 8'hF0, 64'h2000,             64'hCAFEF00D00000000};
        vecs[9]  = '{1'b1, 3'd1, 64'h2003,             64'h1,                  3'd3, 8'h00, 64'h0,                64'h0};
        vecs[10] = '{1'b1, 3'd4, 64'h2000,             64'h1,                  3'd4, 8'h00, 64'h0,                64'h0};

        tick();
        rst = 1'b0;
        chk("rst32_busy", {62'h0, a_busy, a_req}, 64'h0);
        chk("rst32_regs", {a_sbaddress, a_sbdata}, 64'h0);
        chk("rst32_bus", {a_addr, a_wdata}, 64'h0);
        chk("rst32_err", {56'h0, a_be, a_err, a_berr, a_we}, 64'h0);
        chk("rst64_busy", {62'h0, b_busy, b_req}, 64'h0);
        chk("rst64_regs", b_sbaddress | b_sbdata | b_addr | b_wdata, 64'h0);
        chk("rst64_err", {48'h0, b_be, b_err, b_berr, b_we}, 64'h0);

        for (int i = 0; i < 11; i++) begin
            sel64 = vecs[i].w64;
            do_reset();
            sbaccess = vecs[i].acc;
            wr_addr(vecs[i].addr);
            wr_data(vecs[i].data);
            chk($sformatf("v%0d_err", i), {61'h0, m_err}, {61'h0, vecs[i].exp_err});
            if (vecs[i].exp_err == 3'd0) begin
                chk($sformatf("v%0d_req", i), {63'h0, m_req}, 64'h1);
                chk($sformatf("v%0d_we", i), {63'h0, m_we}, 64'h1);
                chk($sformatf("v%0d_be", i), {56'h0, m_be}, {56'h0, vecs[i].exp_be});
                chk($sformatf("v%0d_addr", i), m_addr, vecs[i].exp_addr);
                chk($sformatf("v%0d_wdata", i), m_wdata, vecs[i].exp_wdata);
                finish_access(64'h0);
                chk($sformatf("v%0d_done", i), {62'h0, m_busy, m_req}, 64'h0);
                chk($sformatf("v%0d_addr_kept", i), m_sbaddress, vecs[i].addr);
            end else begin
                chk($sformatf("v%0d_noreq", i), {62'h0, m_busy, m_req}, 64'h0);
            end
        end

        // Read on address with delayed grant; an early rvalid must be ignored.
        sel64 = 1'b0; do_reset(); sbaccess = 3'd2; roa = 1'b1;
        wr_addr(64'h1000);
        roa = 1'b0;
        chk("rd_req_n1", {62'h0, m_req, m_we}, 64'h2);
        chk("rd_addr_o", m_addr, 64'h1000);
        rdata = 64'h55; rvalid = 1'b1;
        tick();
        rvalid = 1'b0;
        chk("rd_early_rvalid", {62'h0, m_busy, m_req}, 64'h3);
        chk("rd_early_data", m_sbdata, 64'h0);
        tick();
        chk("rd_req_hold", {63'h0, m_req}, 64'h1);
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        chk("rd_wait", {62'h0, m_busy, m_req}, 64'h2);
        rdata = 64'hDEADBEEF; rvalid = 1'b1;
        tick();
        rvalid = 1'b0;
        chk("rd_busy_k1", {63'h0, m_busy}, 64'h0);
        chk("rd_data", m_sbdata, 64'hDEADBEEF);

        // 64-bit halfword read at byte offset 6 with autoincrement.
        sel64 = 1'b1; do_reset(); sbaccess = 3'd1; roa = 1'b1; ainc = 1'b1;
        wr_addr(64'h1006);
        roa = 1'b0;
        chk("rd64_be", {56'h0, m_be}, 64'hC0);
        finish_access(64'h1122334455667788);
        chk("rd64_data", m_sbdata, 64'h1122);
        chk("rd64_inc", m_sbaddress, 64'h1008);

        // 64-bit halfword write with autoincrement.
        do_reset();
        wr_addr(64'h1006);
        wr_data(64'hA5A5);
        chk("wr64_be", {56'h0, m_be}, 64'hC0);
        chk("wr64_wdata_hi", {48'h0, m_wdata[63:48]}, 64'hA5A5);
        finish_access(64'hFFFF_FFFF_FFFF_FFFF);
        chk("wr64_inc", m_sbaddress, 64'h1008);
        chk("wr64_data_kept", m_sbdata, 64'hA5A5);
        ainc = 1'b0;

        // Busy error on a second write, then blocking until cleared.
        sel64 = 1'b0; do_reset(); sbaccess = 3'd2;
        wr_addr(64'h1000);
        wr_data(64'h1);
        chk("be_req", {63'h0, m_req}, 64'h1);
        wr_data(64'h2);
        chk("be_set", {63'h0, m_berr}, 64'h1);
        chk("be_inflight", {m_wdata[31:0], 31'h0, m_req}, {32'h1, 32'h1});
        chk("be_reg_kept", m_sbdata, 64'h1);
        finish_access(64'h0);
        chk("be_done", {62'h0, m_busy, m_berr}, 64'h1);
        wr_data(64'h3);
        chk("be_blocked", {63'h0, m_req}, 64'h0);
        chk("be_reg_upd", m_sbdata, 64'h3);
        berr_clr = 1'b1;
        tick();
        berr_clr = 1'b0;
        chk("be_clr", {63'h0, m_berr}, 64'h0);
        wr_data(64'h4);
        chk("be_relaunch", {m_wdata[31:0], 31'h0, m_req}, {32'h4, 32'h1});
        sbdata = 64'h5; sbdata_we = 1'b1; berr_clr = 1'b1;
        tick();
        sbdata_we = 1'b0; berr_clr = 1'b0;
        chk("be_set_wins", {63'h0, m_berr}, 64'h1);
        finish_access(64'h0);

        // Bus error leaves registers alone and blocks; then address wrap.
        do_reset(); sbaccess = 3'd2; ainc = 1'b1; roa = 1'b1;
        wr_addr(64'h1000);
        err = 1'b1;
        finish_access(64'h9999);
        err = 1'b0;
        chk("err_code", {61'h0, m_err}, 64'h2);
        chk("err_addr", m_sbaddress, 64'h1000);
        chk("err_data", m_sbdata, 64'h0);
        wr_addr(64'h1000);
        chk("err_blocks", {62'h0, m_busy, m_req}, 64'h0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_clr", {61'h0, m_err}, 64'h0);
        wr_addr(64'hFFFFFFFC);
        finish_access(64'h12345678);
        chk("wrap_addr", m_sbaddress, 64'h0);
        chk("wrap_data", m_sbdata, 64'h12345678);
        roa = 1'b0; ainc = 1'b0;

        // dmactive drop while waiting for the response.
        do_reset(); sbaccess = 3'd2; roa = 1'b1;
        wr_addr(64'h1000);
        roa = 1'b0;
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        chk("dma_wait", {62'h0, m_busy, m_req}, 64'h2);
        dmactive = 1'b0;
        tick();
        dmactive = 1'b1;
        chk("dma_idle", {61'h0, m_busy, m_req, m_we}, 64'h0);
        chk("dma_regs", m_sbaddress | m_addr | m_wdata | {56'h0, m_be}, 64'h0);
        rdata = 64'hFFFF; rvalid = 1'b1;
        tick();
        rvalid = 1'b0;
        chk("dma_late", {m_sbdata[31:0], 28'h0, m_err, m_busy}, 64'h0);

        // Simultaneous address and data write: write with the new address.
        do_reset(); roa = 1'b1;
        sbaddress = 64'h2000; sbdata = 64'h77; sbaddress_we = 1'b1; sbdata_we = 1'b1;
        tick();
        sbaddress_we = 1'b0; sbdata_we = 1'b0; roa = 1'b0;
        chk("sim_req_we", {62'h0, m_req, m_we}, 64'h3);
        chk("sim_addr", m_addr, 64'h2000);
        chk("sim_wdata", m_wdata, 64'h77);
        finish_access(64'h0);

        // Read on data read.
        do_reset();
        wr_addr(64'h3000);
        chk("rod_noreq", {63'h0, m_req}, 64'h0);
        rod = 1'b1; sbdata_re = 1'b1;
        tick();
        rod = 1'b0; sbdata_re = 1'b0;
        chk("rod_req", {62'h0, m_req, m_we}, 64'h2);
        finish_access(64'hABCD);
        chk("rod_data", m_sbdata, 64'hABCD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
